// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops one byte at a time from a TX FIFO and serialises it
// as start, 8 data bits LSB first, optional even parity, and stop, CLKS_PER_BIT cycles per bit.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       parityEn,
    input  logic       fifoEmpty,
    input  logic [7:0] fifoData,
    output logic       fifoReadEn,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] baud_q;
    logic [15:0] baud_d;
    logic [2:0]  bit_q;
    logic [2:0]  bit_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        par_en_q;
    logic        par_en_d;
    logic        par_bit_q;
    logic        par_bit_d;
    logic        tx_q;
    logic        tx_d;
    logic        read_en_q;
    logic        read_en_d;
    logic        busy_q;
    logic        busy_d;
    logic        baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            read_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            read_en_q <= read_en_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        case (state_q)
            IDLE: begin
                if (enable && !fifoEmpty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                // FIFO data is valid this cycle, one cycle after the pop strobe.
                shift_d   = fifoData;
                par_en_d  = parityEn;
                par_bit_d = ^fifoData;
                baud_d    = 16'd0;
                bit_d     = 3'd0;
                state_d   = START;
            end
            START: begin
                if (baud_done) begin
                    baud_d  = 16'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = 16'd0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            PARITY: begin
                if (baud_done) begin
                    baud_d  = 16'd0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = 16'd0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that they can be registered
    // without adding a cycle of latency to the line.
    always_comb begin
        read_en_d = (state_d == POP);
        busy_d    = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign fifoReadEn = read_en_q;
    assign busy       = busy_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4 and a small array-backed FIFO model.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       parity_en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_read_en;
    logic       tx;
    logic       busy;
    logic [2:0] fsm_state;

    logic [7:0] fifo_mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_count = 0;
    int bad_pops = 0;
    int errors = 0;
    int checks = 0;
    int gap = 0;
    int p0 = 0;
    int n = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .parityEn   (parity_en),
        .fifoEmpty  (fifo_empty),
        .fifoData   (fifo_data),
        .fifoReadEn (fifo_read_en),
        .tx         (tx),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // FIFO model: data appears on fifo_data the cycle after the pop strobe.
    always @(posedge clk) begin
        if (fifo_read_en) begin
            if (wr_ptr == rd_ptr) bad_pops <= bad_pops + 1;
            fifo_data <= fifo_mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 1;
            pop_count <= pop_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr++;
    endtask

    // Waits for the start bit, then checks every cycle of the frame. Returns on the
    // last stop-bit cycle; gap is the number of tx-high cycles seen before the start bit.
    task automatic check_frame(input logic [7:0] b, input logic par, input string tag,
                               output int gap_o);
        logic exp_bits [11];
        int   nbits;
        gap_o = 0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        if (par) begin
            exp_bits[9]  = ^b;
            exp_bits[10] = 1'b1;
            nbits = 11;
        end else begin
            exp_bits[9]  = 1'b1;
            exp_bits[10] = 1'b1;
            nbits = 10;
        end
        @(negedge clk);
        while (tx !== 1'b0 && gap_o < 200) begin
            gap_o++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            check($sformatf("%s start timeout", tag), {31'd0, tx}, 32'd0);
            return;
        end
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < CPB; k++) begin
                if (!(i == 0 && k == 0)) @(negedge clk);
                check($sformatf("%s tx bit%0d cyc%0d", tag, i, k), {31'd0, tx},
                      {31'd0, exp_bits[i]});
                check($sformatf("%s busy bit%0d", tag, i), {31'd0, busy}, 32'd1);
                check($sformatf("%s read_en bit%0d", tag, i), {31'd0, fifo_read_en}, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset read_en", {31'd0, fifo_read_en}, 32'd0);
        check("reset state", {29'd0, fsm_state}, 32'd0);
        reset = 1'b0;

        // Empty FIFO with enable high: nothing happens
        enable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            check("empty tx", {31'd0, tx}, 32'd1);
            check("empty busy", {31'd0, busy}, 32'd0);
            check("empty read_en", {31'd0, fifo_read_en}, 32'd0);
        end
        check("empty pops", pop_count, 32'd0);

        // 0xA5, no parity
        p0 = pop_count;
        push(8'hA5);
        check_frame(8'hA5, 1'b0, "a5", gap);
        @(negedge clk);
        check("a5 idle busy", {31'd0, busy}, 32'd0);
        check("a5 idle tx", {31'd0, tx}, 32'd1);
        check("a5 pops", pop_count - p0, 32'd1);

        // 0x07 with parity; parityEn dropped mid-frame must not matter
        parity_en = 1'b1;
        p0 = pop_count;
        push(8'h07);
        fork
            check_frame(8'h07, 1'b1, "07p", gap);
            begin
                repeat (12) @(negedge clk);
                parity_en = 1'b0;
            end
        join
        @(negedge clk);
        check("07p idle busy", {31'd0, busy}, 32'd0);
        parity_en = 1'b1;
        push(8'hA5);
        check_frame(8'hA5, 1'b1, "a5p", gap);
        check("parity pops", pop_count - p0, 32'd2);
        parity_en = 1'b0;
        @(negedge clk);

        // Three back-to-back frames
        p0 = pop_count;
        push(8'hFF);
        push(8'h00);
        push(8'h6D);
        check_frame(8'hFF, 1'b0, "ff", gap);
        check_frame(8'h00, 1'b0, "00", gap);
        check("gap ff-00", gap, 32'd3);
        check_frame(8'h6D, 1'b0, "6d", gap);
        check("gap 00-6d", gap, 32'd3);
        @(negedge clk);
        check("b2b idle busy", {31'd0, busy}, 32'd0);
        check("b2b pops", pop_count - p0, 32'd3);

        // Enable dropped during DATA with a second byte queued
        p0 = pop_count;
        push(8'h6D);
        push(8'h3C);
        fork
            check_frame(8'h6D, 1'b0, "en 6d", gap);
            begin
                repeat (15) @(negedge clk);
                enable = 1'b0;
            end
        join
        check("en first pop", pop_count - p0, 32'd1);
        repeat (30) begin
            @(negedge clk);
            check("en held read_en", {31'd0, fifo_read_en}, 32'd0);
            check("en held tx", {31'd0, tx}, 32'd1);
            check("en held busy", {31'd0, busy}, 32'd0);
        end
        check("en held pops", pop_count - p0, 32'd1);
        enable = 1'b1;
        check_frame(8'h3C, 1'b0, "en 3c", gap);
        check("en resume pops", pop_count - p0, 32'd2);
        @(negedge clk);

        // Reset pulse during data bit 3 of 0x52 (bit 3 = 0)
        p0 = pop_count;
        push(8'h52);
        push(8'hC3);
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("rst start seen", {31'd0, tx}, 32'd0);
        repeat (4 * CPB + 1) @(negedge clk);
        check("rst bit3 tx", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst tx", {31'd0, tx}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst read_en", {31'd0, fifo_read_en}, 32'd0);
        check("rst state", {29'd0, fsm_state}, 32'd0);
        check("rst pops", pop_count - p0, 32'd1);
        check_frame(8'hC3, 1'b0, "rst c3", gap);
        check("rst after pops", pop_count - p0, 32'd2);
        @(negedge clk);
        check("rst final busy", {31'd0, busy}, 32'd0);
        check("fifo drained", {31'd0, fifo_empty}, 32'd1);
        check("no pop while empty", bad_pops, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
